// File: rtl/regbank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_arbiter
//  Purpose  : Two-requester arbiter in front of a single-port register bank.
//             Lock/burst-limited ownership, one-cycle read responses and a
//             register 0 that can never be written.
//  Revision : 1.0  initial release
// ============================================================================
module regbank_arbiter #(
  parameter int SEL_W     = 5,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic              req0_lock,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  // requester 1
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic              req1_lock,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  // register bank
  output logic [SEL_W-1:0]  rb_sel,
  output logic [DATA_W-1:0] rb_data_in,
  output logic              rb_write_reg,
  input  logic [DATA_W-1:0] rb_data_out
);

  // MAX_BURST is limited to 1..15, so four bits always hold the counter.
  localparam int              BURST_W   = 4;
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  // Arbiter state: owner is the last accepted requester (1 out of reset so
  // requester 0 wins the first contention); lock_hold remembers that the
  // accept in the immediately preceding cycle asked to keep the grant.
  logic               owner;
  logic               lock_hold;
  logic [BURST_W-1:0] burst_cnt;

  logic grant0;
  logic grant1;
  logic accept;
  logic acc_lock;

  // Grant decision: a lone valid wins at once; under contention the owner
  // keeps the bank only while its lock is live and the burst limit allows.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (req0_valid && req1_valid) begin
        if (lock_hold && (burst_cnt < BURST_MAX)) begin
          grant0 = ~owner;
          grant1 = owner;
        end else begin
          grant0 = owner;
          grant1 = ~owner;
        end
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;
  assign acc_lock   = grant1 ? req1_lock : req0_lock;

  // Bank command mux: the granted request goes straight to the bank; register
  // 0 is read-only zero, so a write to it is accepted but never strobed.
  always_comb begin
    rb_sel       = '0;
    rb_data_in   = '0;
    rb_write_reg = 1'b0;
    if (grant0) begin
      rb_sel       = req0_sel;
      rb_data_in   = req0_wdata;
      rb_write_reg = req0_we && (req0_sel != '0);
    end else if (grant1) begin
      rb_sel       = req1_sel;
      rb_data_in   = req1_wdata;
      rb_write_reg = req1_we && (req1_sel != '0);
    end
  end

  // Ownership, lock and burst tracking; an idle cycle breaks any lock and
  // restarts the burst count but leaves the owner in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= 1'b1;
      lock_hold <= 1'b0;
      burst_cnt <= '0;
    end else if (accept) begin
      owner     <= grant1;
      lock_hold <= acc_lock;
      if (grant1 != owner) begin
        burst_cnt <= BURST_W'(1);
      end else if (burst_cnt < BURST_MAX) begin
        burst_cnt <= burst_cnt + BURST_W'(1);
      end
    end else begin
      lock_hold <= 1'b0;
      burst_cnt <= '0;
    end
  end

  // Read response pulses: the bank returns data one cycle after the select,
  // so an accepted read flags the following cycle for its requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      rsp0_valid <= grant0 & ~req0_we;
      rsp1_valid <= grant1 & ~req1_we;
    end
  end

  assign rsp0_rdata = rsp0_valid ? rb_data_out : '0;
  assign rsp1_rdata = rsp1_valid ? rb_data_out : '0;

endmodule
`default_nettype wire

// File: tb/tb_regbank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regbank_arbiter
//  Purpose  : Self-checking bench for regbank_arbiter with a register bank
//             model, directed vector table and randomized traffic against a
//             history-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regbank_arbiter;

  localparam int SEL_W     = 5;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic bank_clr;

  logic              req0_valid, req0_we, req0_lock, req0_ready, rsp0_valid;
  logic [SEL_W-1:0]  req0_sel;
  logic [DATA_W-1:0] req0_wdata, rsp0_rdata;
  logic              req1_valid, req1_we, req1_lock, req1_ready, rsp1_valid;
  logic [SEL_W-1:0]  req1_sel;
  logic [DATA_W-1:0] req1_wdata, rsp1_rdata;
  logic [SEL_W-1:0]  rb_sel;
  logic [DATA_W-1:0] rb_data_in, rb_data_out;
  logic              rb_write_reg;

  regbank_arbiter #(.SEL_W(SEL_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_sel(req0_sel), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_sel(req1_sel), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .rb_sel(rb_sel), .rb_data_in(rb_data_in), .rb_write_reg(rb_write_reg),
    .rb_data_out(rb_data_out)
  );

  always #5 clk = ~clk;

  // Register bank: read-before-write, registered read data.
  logic [DATA_W-1:0] bank [32];
  always @(posedge clk) begin
    if (bank_clr) begin
      for (int i = 0; i < 32; i++) bank[i] <= '0;
    end else if (rb_write_reg) begin
      bank[rb_sel] <= rb_data_in;
    end
    rb_data_out <= bank[rb_sel];
  end

  typedef struct {
    logic v0, we0, lk0; logic [4:0] s0; logic [7:0] d0;
    logic v1, we1, lk1; logic [4:0] s1; logic [7:0] d1;
    logic [1:0] rdy; logic wr; logic [4:0] rsel; logic [7:0] rdin;
    logic [1:0] rspv; logic [7:0] q0, q1;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: grant history per cycle (-1 = idle) plus lock of each accept.
  int          hist_g[$];
  bit          hist_lk[$];
  logic [7:0]  m_mem [32];
  int          m_pend;
  logic [7:0]  m_pend_data;

  function automatic int model_grant(input logic v0, input logic v1);
    int owner = 1;
    int streak = 0;
    bit held;
    for (int i = hist_g.size() - 1; i >= 0; i--)
      if (hist_g[i] >= 0) begin owner = hist_g[i]; break; end
    for (int i = hist_g.size() - 1; i >= 0; i--) begin
      if (hist_g[i] != owner) break;
      streak++;
    end
    held = (hist_g.size() > 0) && (hist_g[hist_g.size()-1] == owner) && hist_lk[hist_lk.size()-1];
    if (v0 && v1) return (held && streak < MAX_BURST) ? owner : 1 - owner;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic vec_t predict(input vec_t v);
    vec_t e = v;
    int g = model_grant(v.v0, v.v1);
    e.rdy = 2'b00; e.wr = 1'b0; e.rsel = '0; e.rdin = '0;
    if (g == 0) begin
      e.rdy = 2'b01; e.rsel = v.s0; e.rdin = v.d0; e.wr = v.we0 && (v.s0 != 0);
    end else if (g == 1) begin
      e.rdy = 2'b10; e.rsel = v.s1; e.rdin = v.d1; e.wr = v.we1 && (v.s1 != 0);
    end
    e.rspv = (m_pend == 0) ? 2'b01 : (m_pend == 1) ? 2'b10 : 2'b00;
    e.q0   = (m_pend == 0) ? m_pend_data : 8'h00;
    e.q1   = (m_pend == 1) ? m_pend_data : 8'h00;
    return e;
  endfunction

  task automatic commit(input vec_t v);
    int g = model_grant(v.v0, v.v1);
    logic we; logic [4:0] s; logic [7:0] d;
    m_pend = -1;
    hist_g.push_back(g);
    hist_lk.push_back(g == 0 ? v.lk0 : g == 1 ? v.lk1 : 1'b0);
    if (g >= 0) begin
      we = (g == 0) ? v.we0 : v.we1;
      s  = (g == 0) ? v.s0 : v.s1;
      d  = (g == 0) ? v.d0 : v.d1;
      if (!we) begin
        m_pend = g; m_pend_data = m_mem[s];
      end else if (s != 0) begin
        m_mem[s] = d;
      end
    end
  endtask

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s %s: got 0x%0h expected 0x%0h at %0t", tag, name, act, exp, $time);
  endtask

  task automatic check(input vec_t e, input string tag);
    chk(tag, "ready",        {30'd0, req1_ready, req0_ready}, {30'd0, e.rdy});
    chk(tag, "rb_write_reg", {31'd0, rb_write_reg},            {31'd0, e.wr});
    chk(tag, "rb_sel",       {27'd0, rb_sel},                  {27'd0, e.rsel});
    chk(tag, "rb_data_in",   {24'd0, rb_data_in},              {24'd0, e.rdin});
    chk(tag, "rsp_valid",    {30'd0, rsp1_valid, rsp0_valid},  {30'd0, e.rspv});
    chk(tag, "rsp0_rdata",   {24'd0, rsp0_rdata},              {24'd0, e.q0});
    chk(tag, "rsp1_rdata",   {24'd0, rsp1_rdata},              {24'd0, e.q1});
  endtask

  task automatic drive(input vec_t v);
    req0_valid = v.v0; req0_we = v.we0; req0_lock = v.lk0; req0_sel = v.s0; req0_wdata = v.d0;
    req1_valid = v.v1; req1_we = v.we1; req1_lock = v.lk1; req1_sel = v.s1; req1_wdata = v.d1;
  endtask

  // Called at posedge+1: drive, check mid-cycle, advance, update model.
  task automatic run_cycle(input vec_t v, input bit use_tab, input string tag);
    vec_t e;
    drive(v);
    e = use_tab ? v : predict(v);
    #4;
    check(e, tag);
    @(posedge clk); #1;
    commit(v);
  endtask

  // Called at posedge+1: assert reset with live requests and check outputs.
  task automatic reset_check(input string tag);
    vec_t z;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b1; req0_lock = 1'b1; req0_sel = 5'd9; req0_wdata = 8'h3C;
    req1_valid = 1'b1; req1_we = 1'b0; req1_lock = 1'b1; req1_sel = 5'd9; req1_wdata = 8'hC3;
    #2;
    z = '{default: '0};
    check(z, tag);
    hist_g.delete(); hist_lk.delete(); m_pend = -1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(
    input logic v0, we0, lk0, input logic [4:0] s0, input logic [7:0] d0,
    input logic v1, we1, lk1, input logic [4:0] s1, input logic [7:0] d1,
    input logic [1:0] rdy, input logic wr, input logic [4:0] rsel, input logic [7:0] rdin,
    input logic [1:0] rspv, input logic [7:0] q0, input logic [7:0] q1);
    vec_t r;
    r.v0 = v0; r.we0 = we0; r.lk0 = lk0; r.s0 = s0; r.d0 = d0;
    r.v1 = v1; r.we1 = we1; r.lk1 = lk1; r.s1 = s1; r.d1 = d1;
    r.rdy = rdy; r.wr = wr; r.rsel = rsel; r.rdin = rdin;
    r.rspv = rspv; r.q0 = q0; r.q1 = q1;
    return r;
  endfunction

  vec_t tab [23];

  initial begin
    vec_t v;
    bit p0, p1;

    // Directed table: expected values worked out by hand from the rules.
    tab[0]  = mk(1,0,0,3,8'h00, 1,0,0,4,8'h00, 2'b01,0,3,8'h00, 2'b00,8'h00,8'h00);
    tab[1]  = mk(0,0,0,0,8'h00, 1,0,0,4,8'h00, 2'b10,0,4,8'h00, 2'b01,8'h00,8'h00);
    tab[2]  = mk(0,0,0,0,8'h00, 0,0,0,0,8'h00, 2'b00,0,0,8'h00, 2'b10,8'h00,8'h00);
    tab[3]  = mk(1,1,0,7,8'hA5, 0,0,0,0,8'h00, 2'b01,1,7,8'hA5, 2'b00,8'h00,8'h00);
    tab[4]  = mk(0,0,0,0,8'h00, 1,0,0,7,8'h00, 2'b10,0,7,8'h00, 2'b00,8'h00,8'h00);
    tab[5]  = mk(0,0,0,0,8'h00, 0,0,0,0,8'h00, 2'b00,0,0,8'h00, 2'b10,8'h00,8'hA5);
    tab[6]  = mk(1,1,0,0,8'hFF, 0,0,0,0,8'h00, 2'b01,0,0,8'hFF, 2'b00,8'h00,8'h00);
    tab[7]  = mk(1,0,0,0,8'h00, 0,0,0,0,8'h00, 2'b01,0,0,8'h00, 2'b00,8'h00,8'h00);
    tab[8]  = mk(0,0,0,0,8'h00, 0,0,0,0,8'h00, 2'b00,0,0,8'h00, 2'b01,8'h00,8'h00);
    tab[9]  = mk(0,0,0,0,8'h00, 1,1,1,5,8'h01, 2'b10,1,5,8'h01, 2'b00,8'h00,8'h00);
    tab[10] = mk(1,0,0,2,8'h00, 1,1,1,5,8'h02, 2'b10,1,5,8'h02, 2'b00,8'h00,8'h00);
    tab[11] = mk(1,0,0,2,8'h00, 1,1,1,5,8'h03, 2'b10,1,5,8'h03, 2'b00,8'h00,8'h00);
    tab[12] = mk(1,0,0,2,8'h00, 1,1,1,5,8'h04, 2'b10,1,5,8'h04, 2'b00,8'h00,8'h00);
    tab[13] = mk(1,0,0,2,8'h00, 1,1,1,5,8'h05, 2'b01,0,2,8'h00, 2'b00,8'h00,8'h00);
    tab[14] = mk(1,0,0,2,8'h00, 1,1,1,5,8'h05, 2'b10,1,5,8'h05, 2'b01,8'h00,8'h00);
    tab[15] = mk(1,0,0,2,8'h00, 1,1,1,5,8'h06, 2'b10,1,5,8'h06, 2'b00,8'h00,8'h00);
    tab[16] = mk(1,0,0,2,8'h00, 0,0,0,0,8'h00, 2'b01,0,2,8'h00, 2'b00,8'h00,8'h00);
    tab[17] = mk(0,0,0,0,8'h00, 0,0,0,0,8'h00, 2'b00,0,0,8'h00, 2'b01,8'h00,8'h00);
    tab[18] = mk(1,0,0,7,8'h00, 1,0,0,5,8'h00, 2'b10,0,5,8'h00, 2'b00,8'h00,8'h00);
    tab[19] = mk(1,0,0,7,8'h00, 1,0,0,5,8'h00, 2'b01,0,7,8'h00, 2'b10,8'h00,8'h06);
    tab[20] = mk(1,0,0,7,8'h00, 1,0,0,5,8'h00, 2'b10,0,5,8'h00, 2'b01,8'hA5,8'h00);
    tab[21] = mk(1,0,0,7,8'h00, 1,0,0,5,8'h00, 2'b01,0,7,8'h00, 2'b10,8'h00,8'h06);
    tab[22] = mk(0,0,0,0,8'h00, 0,0,0,0,8'h00, 2'b00,0,0,8'h00, 2'b01,8'hA5,8'h00);

    rst_n = 1'b0;
    bank_clr = 1'b1;
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_pend = -1;
    m_pend_data = '0;
    @(posedge clk); #1;
    reset_check("por");
    bank_clr = 1'b0;

    for (int i = 0; i < 23; i++) run_cycle(tab[i], 1'b1, $sformatf("tab%0d", i));

    // Reset the cycle after a read is accepted: the pulse must be dropped.
    v = mk(1,0,0,7,8'h00, 0,0,0,0,8'h00, 2'b00,0,0,8'h00, 2'b00,8'h00,8'h00);
    run_cycle(v, 1'b0, "rd_before_rst");
    reset_check("rst_mid");
    v = mk(0,0,0,0,8'h00, 0,0,0,0,8'h00, 2'b00,0,0,8'h00, 2'b00,8'h00,8'h00);
    run_cycle(v, 1'b0, "after_rst_idle");
    // First contention after reset goes to requester 0.
    v = mk(1,0,0,7,8'h00, 1,0,0,5,8'h00, 2'b00,0,0,8'h00, 2'b00,8'h00,8'h00);
    run_cycle(v, 1'b0, "after_rst_cont");
    run_cycle(v, 1'b0, "after_rst_cont2");

    // Randomized traffic; each requester holds its request until accepted.
    v = '{default: '0};
    p0 = 1'b0; p1 = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1'b1; v.we0 = 1'($urandom); v.lk0 = ($urandom_range(0, 2) != 0);
        v.s0 = 5'($urandom_range(0, 7)); v.d0 = 8'($urandom);
      end
      if (!p1 && $urandom_range(0, 3) != 0) begin
        p1 = 1'b1; v.we1 = 1'($urandom); v.lk1 = ($urandom_range(0, 2) != 0);
        v.s1 = 5'($urandom_range(0, 7)); v.d1 = 8'($urandom);
      end
      v.v0 = p0; v.v1 = p1;
      if ($urandom_range(0, 249) == 0) begin
        reset_check("rnd_rst");
      end else begin
        run_cycle(v, 1'b0, "rnd");
        if (hist_g[hist_g.size()-1] == 0) p0 = 1'b0;
        if (hist_g[hist_g.size()-1] == 1) p1 = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regbank_arbiter.md
REGBANK_ARBITER -- requirements
Module: regbank_arbiter

Interface
REQ-001 Parameter: SEL_W, 5, register select width (32 registers).
REQ-002 Parameter: DATA_W, 8, register data width.
REQ-003 Parameter: MAX_BURST, 4, max consecutive locked grants to one requester (range 1..15).
REQ-004 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-005 Ports, for N in {0,1}, SHALL be:
- clk  in  1  rising-edge clock.
- rst_n  in  1  async active-low reset.
- reqN_valid  in  1  requester N presents a transaction.
- reqN_we  in  1  1=write, 0=read.
- reqN_lock  in  1  request to keep the grant next cycle.
- reqN_sel  in  SEL_W  register index.
- reqN_wdata  in  DATA_W  write data.
- reqN_ready  out  1  transaction accepted this cycle.
- rspN_valid  out  1  read data valid pulse.
- rspN_rdata  out  DATA_W  read data.
- rb_sel  out  SEL_W  bank select.
- rb_data_in  out  DATA_W  bank write data.
- rb_write_reg  out  1  bank write strobe.
- rb_data_out  in  DATA_W  bank registered read data, valid one cycle after select.

Function
REQ-006 A transaction SHALL be accepted on a rising clk edge when reqN_valid=1 and reqN_ready=1; at most one requester SHALL be ready per cycle.
REQ-007 reqN_ready SHALL be combinational from the valids and arbiter state; a lone valid requester SHALL be granted in the same cycle.
REQ-008 When both are valid, the grant SHALL go to the owner (last accepted requester) if its previous accept had lock=1, was in the immediately preceding cycle, and burst_cnt < MAX_BURST; otherwise the grant SHALL go to the non-owner.
REQ-009 burst_cnt SHALL be 1 on an accept that changes owner, increment on a consecutive accept by the same owner (saturating at MAX_BURST), and clear to 0 on any cycle with no accept.
REQ-010 On an idle cycle (no accept), owner SHALL be unchanged and the lock hold SHALL be cleared.
REQ-011 rb_sel, rb_data_in, and rb_write_reg SHALL be driven combinationally from the granted requester; with no grant, rb_sel=0, rb_data_in=0, and rb_write_reg=0.
REQ-012 rb_write_reg SHALL equal the granted reqN_we, except that it SHALL be 0 when reqN_sel=0 (register 0 is hardwired to zero); such a write SHALL still be accepted.
REQ-013 For an accepted read, rspN_valid SHALL be a registered one-cycle pulse in the cycle after acceptance; rspN_rdata SHALL equal rb_data_out in that cycle and SHALL be 0 otherwise.
REQ-014 Writes SHALL produce no response pulse.
REQ-015 Read latency SHALL be exactly 1 cycle with no response backpressure; back-to-back reads SHALL yield back-to-back pulses.
REQ-016 A read accepted in the same cycle as a write to the same register SHALL return the old value; a read accepted one cycle after the write SHALL return the new value.
REQ-017 Requests SHALL be held stable by the requester until accepted; the arbiter SHALL NOT store them.

Reset
REQ-018 While rst_n=0: reqN_ready=0, rspN_valid=0, rspN_rdata=0, rb_write_reg=0, rb_sel=0, rb_data_in=0, burst_cnt=0, and owner=1, so that requester 0 wins the first contention.
REQ-019 Reset asserted mid-transaction SHALL drop any pending response pulse, with no rb_write_reg glitch.
REQ-020 Operation SHALL resume on the first rising clk edge after rst_n deasserts.

Verification
REQ-021 Reset release, then both requesters issue reads simultaneously (req0 sel=3, req1 sel=4) -> req0 is granted first and req1 next cycle; rsp0_valid and then rsp1_valid each pulse one cycle after their grants.
REQ-022 req0 writes 0xA5 to sel=7; next cycle req1 reads sel=7 -> rsp1_rdata=0xA5 one cycle after acceptance.
REQ-023 req0 writes 0xFF to sel=0 and later reads sel=0 -> rb_write_reg stays 0, req0_ready=1, and rsp0_rdata=0x00.
REQ-024 req1 holds lock=1 with 6 back-to-back writes while req0 is continuously valid -> req1 gets 4 consecutive grants, then req0 is granted, then req1 again.
REQ-025 Both requesters continuously valid with lock=0 -> grants alternate 0,1,0,1 and burst_cnt never exceeds 1.
REQ-026 rst_n pulled low the cycle after a read is accepted -> no rsp pulse and all outputs are 0 while reset is asserted.
